pc_fetch_sequencer: RTL and testbench

//   Owns the program counter and drives it into the PC adder. Each cycle it

---
 rtl/pc_fetch_sequencer.sv | 144 ++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
// Holds the program counter, presents it as the fetch address over a
// valid/ready handshake, and chooses the next PC from the adder result,
// a pending redirect, or a redirect arriving this cycle.
// Jump redirects win over branch redirects. Targets are forced to word
// alignment, and an unaligned target raises a one-cycle MisalignErr pulse.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [31:0]      PCAddResult,
    input  logic             Jump,
    input  logic [31:0]      JumpTarget,
    input  logic             BranchTaken,
    input  logic [31:0]      BranchTarget,
    input  logic             Stall,
    input  logic             FetchReady,
    output logic [31:0]      PCResult,
    output logic             FetchValid,
    output logic             MisalignErr,
    output logic [CNT_W-1:0] FetchCount
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               pend_valid_q, pend_valid_d;
    logic [31:0]        pend_pc_q, pend_pc_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic               misalign_q, misalign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               redir_valid;
    logic [31:0]        redir_raw;
    logic [31:0]        redir_aligned;
    logic               redir_misalign;
    logic               handshake;

    // Resolve this cycle's redirect: jump has priority; force word alignment.
    always_comb begin
        redir_valid    = Jump | BranchTaken;
        redir_raw      = Jump ? JumpTarget : BranchTarget;
        redir_aligned  = {redir_raw[31:2], 2'b00};
        redir_misalign = redir_valid & (redir_raw[1:0] != 2'b00);
        handshake      = fetch_valid_q & FetchReady;
    end

    // Next-state logic for the fetch FSM, PC, pending redirect and counter.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        cnt_d        = cnt_q;
        // Every redirect is either applied or captured the cycle it arrives,
        // so the error pulse follows the arrival cycle in every state.
        // A captured target is stored aligned, so it never pulses twice.
        misalign_d   = redir_misalign;

        case (state_q)
            ST_IDLE: begin
                if (redir_valid) begin
                    pc_d         = redir_aligned;
                    pend_valid_d = 1'b0;
                end
                state_d = Stall ? ST_STALL : ST_REQ;
            end

            ST_REQ: begin
                if (handshake) begin
                    if (redir_valid) begin
                        pc_d = redir_aligned;
                    end else if (pend_valid_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        // Adder output is used as-is; 0xFFFF_FFFC + 4 wraps to 0.
                        pc_d = PCAddResult;
                    end
                    pend_valid_d = 1'b0;
                    cnt_d        = cnt_q + CNT_ONE;
                    state_d      = Stall ? ST_STALL : ST_REQ;
                end else if (redir_valid) begin
                    // The address must stay stable until the handshake, so
                    // the redirect waits. A newer redirect replaces an older one.
                    pend_valid_d = 1'b1;
                    pend_pc_d    = redir_aligned;
                end
            end

            ST_STALL: begin
                if (redir_valid) begin
                    pc_d         = redir_aligned;
                    pend_valid_d = 1'b0;
                end
                if (!Stall) begin
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d      = ST_IDLE;
                pend_valid_d = 1'b0;
            end
        endcase

        fetch_valid_d = (state_d == ST_REQ);
    end

    // State and registered outputs; reset takes effect without a clock edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_pc_q     <= 32'h0000_0000;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_pc_q     <= pend_pc_d;
            fetch_valid_q <= fetch_valid_d;
            misalign_q    <= misalign_d;
            cnt_q         <= cnt_d;
        end
    end

    assign PCResult    = pc_q;
    assign FetchValid  = fetch_valid_q;
    assign MisalignErr = misalign_q;
    assign FetchCount  = cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer.
// Each vector holds the inputs driven for one cycle and the outputs expected
// after the following rising edge. Expected records go into a scoreboard
// queue when the inputs are driven, and are compared after that edge.
module tb_pc_fetch_sequencer;

    localparam int CW = 4;

    typedef struct {
        logic          jump;
        logic [31:0]   jt;
        logic          br;
        logic [31:0]   bt;
        logic          stall;
        logic          ready;
        logic [31:0]   pc;
        logic          valid;
        logic          mis;
        logic [CW-1:0] cnt;
    } vec_t;

    logic          Clk;
    logic          Reset;
    logic [31:0]   PCAddResult;
    logic          Jump;
    logic [31:0]   JumpTarget;
    logic          BranchTaken;
    logic [31:0]   BranchTarget;
    logic          Stall;
    logic          FetchReady;
    logic [31:0]   PCResult;
    logic          FetchValid;
    logic          MisalignErr;
    logic [CW-1:0] FetchCount;

    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;
    vec_t sb_q[$];
    vec_t vecs[25];

    pc_fetch_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(CW)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .PCAddResult  (PCAddResult),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Stall        (Stall),
        .FetchReady   (FetchReady),
        .PCResult     (PCResult),
        .FetchValid   (FetchValid),
        .MisalignErr  (MisalignErr),
        .FetchCount   (FetchCount)
    );

    // The external PC adder.
    assign PCAddResult = PCResult + 32'd4;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic j, input logic [31:0] jt,
                                input logic b, input logic [31:0] bt,
                                input logic st, input logic rd,
                                input logic [31:0] pc, input logic v,
                                input logic m, input logic [CW-1:0] c);
        vec_t r;
        r.jump = j;  r.jt = jt;  r.br = b;  r.bt = bt;
        r.stall = st; r.ready = rd;
        r.pc = pc;   r.valid = v; r.mis = m; r.cnt = c;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (txn %0d)", name, act, exp, txn);
        end
    endtask

    // Drive one vector from a falling edge, compare after the next rising edge,
    // and return at the following falling edge.
    task automatic apply(input vec_t v);
        vec_t e;
        Jump         = v.jump;
        JumpTarget   = v.jt;
        BranchTaken  = v.br;
        BranchTarget = v.bt;
        Stall        = v.stall;
        FetchReady   = v.ready;
        sb_q.push_back(v);
        @(posedge Clk);
        #1;
        e = sb_q.pop_front();
        $display("TXN %0d j=%0d b=%0d st=%0d rdy=%0d -> pc=%h valid=%0d mis=%0d cnt=%0d",
                 txn, e.jump, e.br, e.stall, e.ready, PCResult, FetchValid, MisalignErr, FetchCount);
        chk("pc",    PCResult,              e.pc);
        chk("valid", {31'b0, FetchValid},   {31'b0, e.valid});
        chk("mis",   {31'b0, MisalignErr},  {31'b0, e.mis});
        chk("cnt",   {28'b0, FetchCount},   {28'b0, e.cnt});
        txn++;
        @(negedge Clk);
    endtask

    initial begin
        // Sequential fetch from reset.
        vecs[0]  = mk(0, 0,      0, 0,      0, 1, 32'h000, 1, 0, 0);
        vecs[1]  = mk(0, 0,      0, 0,      0, 1, 32'h004, 1, 0, 1);
        vecs[2]  = mk(0, 0,      0, 0,      0, 1, 32'h008, 1, 0, 2);
        vecs[3]  = mk(0, 0,      0, 0,      0, 1, 32'h00C, 1, 0, 3);
        vecs[4]  = mk(0, 0,      0, 0,      0, 1, 32'h010, 1, 0, 4);
        // Jump held pending while the memory is not ready.
        vecs[5]  = mk(1, 32'h100, 0, 0,     0, 0, 32'h010, 1, 0, 4);
        vecs[6]  = mk(0, 0,      0, 0,      0, 0, 32'h010, 1, 0, 4);
        vecs[7]  = mk(0, 0,      0, 0,      0, 0, 32'h010, 1, 0, 4);
        vecs[8]  = mk(0, 0,      0, 0,      0, 1, 32'h100, 1, 0, 5);
        // Jump beats a branch in the same cycle.
        vecs[9]  = mk(1, 32'h200, 1, 32'h300, 0, 1, 32'h200, 1, 0, 6);
        vecs[10] = mk(1, 32'h010, 0, 0,     0, 1, 32'h010, 1, 0, 7);
        // Stall at handshake, then a branch while stalled, then resume.
        vecs[11] = mk(0, 0,      0, 0,      1, 1, 32'h014, 0, 0, 8);
        vecs[12] = mk(0, 0,      0, 0,      1, 1, 32'h014, 0, 0, 8);
        vecs[13] = mk(0, 0,      1, 32'h040, 1, 1, 32'h040, 0, 0, 8);
        vecs[14] = mk(0, 0,      0, 0,      0, 1, 32'h040, 1, 0, 8);
        vecs[15] = mk(0, 0,      0, 0,      0, 1, 32'h044, 1, 0, 9);
        // Unaligned branch applied at handshake, then unaligned jump captured.
        vecs[16] = mk(0, 0,      1, 32'h103, 0, 1, 32'h100, 1, 1, 10);
        vecs[17] = mk(0, 0,      0, 0,      0, 1, 32'h104, 1, 0, 11);
        vecs[18] = mk(1, 32'h202, 0, 0,     0, 0, 32'h104, 1, 1, 11);
        vecs[19] = mk(0, 0,      0, 0,      0, 1, 32'h200, 1, 0, 12);
        // A newer redirect replaces the pending one; stall ignored without handshake.
        vecs[20] = mk(1, 32'h300, 0, 0,     0, 0, 32'h200, 1, 0, 12);
        vecs[21] = mk(0, 0,      1, 32'h380, 0, 0, 32'h200, 1, 0, 12);
        vecs[22] = mk(0, 0,      0, 0,      0, 1, 32'h380, 1, 0, 13);
        vecs[23] = mk(0, 0,      0, 0,      1, 0, 32'h380, 1, 0, 13);
        vecs[24] = mk(0, 0,      0, 0,      0, 1, 32'h384, 1, 0, 14);

        Jump = 0; JumpTarget = 0; BranchTaken = 0; BranchTarget = 0;
        Stall = 0; FetchReady = 1;
        Reset = 1'b0;
        #1 Reset = 1'b1;
        #2;
        chk("rst_pc",    PCResult,             32'h0);
        chk("rst_valid", {31'b0, FetchValid},  32'h0);
        chk("rst_mis",   {31'b0, MisalignErr}, 32'h0);
        chk("rst_cnt",   {28'b0, FetchCount},  32'h0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            apply(vecs[i]);
        end

        // Address wrap at the top of memory; the counter also wraps here.
        apply(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0, 15));
        apply(mk(0, 0, 0, 0, 0, 1, 32'h0000_0000, 1, 0, 0));
        apply(mk(0, 0, 0, 0, 0, 1, 32'h0000_0004, 1, 0, 1));

        // Asynchronous reset in the middle of a request, between clock edges.
        FetchReady = 1'b0;
        #2 Reset = 1'b1;
        #1;
        $display("TXN %0d async reset -> pc=%h valid=%0d cnt=%0d", txn, PCResult, FetchValid, FetchCount);
        chk("arst_pc",    PCResult,             32'h0);
        chk("arst_valid", {31'b0, FetchValid},  32'h0);
        chk("arst_cnt",   {28'b0, FetchCount},  32'h0);
        txn++;
        @(negedge Clk);
        Reset = 1'b0;

        // Unaligned jump during the idle cycle loads the PC directly.
        apply(mk(1, 32'h501, 0, 0, 0, 1, 32'h500, 1, 1, 0));
        for (int k = 1; k <= 18; k++) begin
            logic [CW-1:0] c;
            c = CW'(k % 16);
            apply(mk(0, 0, 0, 0, 0, 1, 32'h500 + 32'(4 * k), 1, 0, c));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
